// File: rtl/sub_seq_if.sv
// Operand/result bundle for the multi-cycle subtractor.
// master drives the request and operands; slave returns status and flags.
// Carries no timing of its own; all handshake timing lives in sub_seq.
interface sub_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, zero
  );
endinterface

// File: rtl/sub_seq.sv
// Multi-cycle a - b, one nibble per clock through a single 4-bit CLA slice.
// Latency: start edge -> WIDTH/4 RUN cycles -> one-cycle done pulse.
// No backpressure: start is only sampled in IDLE, ignored while busy or done.
module sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  sub_seq_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] scratch;
  logic [WIDTH-1:0] scratch_nxt;
  logic             carry;
  logic [KW-1:0]    k;
  logic             last;
  logic [3:0]       a_nib;
  logic [3:0]       nb_nib;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [4:0]       c;
  logic [3:0]       sum4;
  logic             cout;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;

  assign last = (k == KW'(N - 1));

  // 4-bit carry-lookahead slice on the current nibble; b is inverted so the
  // stored carry (seeded with 1) turns the add into a two's-complement subtract.
  always_comb begin
    a_nib  = a_q[k*4 +: 4];
    nb_nib = ~b_q[k*4 +: 4];
    g      = a_nib & nb_nib;
    p      = a_nib ^ nb_nib;
    c      = '0;
    c[0]   = carry;
    c[1]   = g[0] | (p[0] & c[0]);
    c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum4   = p ^ c[3:0];
    cout   = c[4];
    scratch_nxt            = scratch;
    scratch_nxt[k*4 +: 4]  = sum4;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for N nibbles, DONE for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand capture, nibble stepping, and result/flag registers. Results are
  // loaded from the merged final scratch on the edge entering DONE so they are
  // valid in the same cycle as the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      scratch  <= '0;
      carry    <= 1'b0;
      k        <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry   <= 1'b1;
            k       <= '0;
            scratch <= '0;
          end
        end
        RUN: begin
          scratch <= scratch_nxt;
          carry   <= cout;
          k       <= k + 1'b1;
          if (last) begin
            diff_q   <= scratch_nxt;
            borrow_q <= ~cout;
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (scratch_nxt[WIDTH-1] != a_q[WIDTH-1]);
            zero_q   <= (scratch_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule
